// File: rtl/btn_pkg.sv
// Shared types and default sizing for the front-panel button event scheduler.
package btn_pkg;

  localparam int N_BTN_DEFAULT      = 5;
  localparam int TICK_DIV_DEFAULT   = 100_000;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  localparam int BTN_ID_W = $clog2(N_BTN_DEFAULT);

  typedef logic [BTN_ID_W-1:0] btn_id_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO of button ids; head reads 0 whenever the queue is empty.
module event_fifo
  import btn_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int W     = BTN_ID_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/btn_event_scheduler.sv
// Samples all buttons on one shared tick, latches presses as pending events and
// feeds them round-robin into an event queue drained over valid/ready.
module btn_event_scheduler
  import btn_pkg::*;
#(
  parameter int N_BTN      = N_BTN_DEFAULT,
  parameter int TICK_DIV   = TICK_DIV_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic                     sample_tick,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  input  logic                     evt_ready,
  output logic                     overrun
);

  localparam int ID_W  = $clog2(N_BTN);
  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt;
  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] btn_sync;
  logic [N_BTN-1:0] btn_stable;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] grant_mask;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic             grant_valid;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  assign sample_tick = (cnt == CNT_W'(TICK_DIV - 1));
  assign press       = sample_tick ? (btn_sync & ~btn_stable) : '0;

  // Round-robin scan starting just above the last granted button.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_id    = '0;
    if ((|pending) && !fifo_full) begin
      for (int k = 1; k <= N_BTN; k++) begin
        idx = (int'(rr_ptr) + k) % N_BTN;
        if (!grant_valid && pending[ID_W'(idx)]) begin
          grant_valid = 1'b1;
          grant_id    = ID_W'(idx);
        end
      end
    end
    grant_mask = grant_valid ? (N_BTN'(1) << grant_id) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      sync1      <= '0;
      btn_sync   <= '0;
      btn_stable <= '0;
      pending    <= '0;
      rr_ptr     <= ID_W'(N_BTN - 1);
      overrun    <= 1'b0;
    end else begin
      cnt      <= sample_tick ? '0 : cnt + CNT_W'(1);
      sync1    <= btn_raw;
      btn_sync <= sync1;
      if (sample_tick) btn_stable <= btn_sync;
      // A press landing on the bit being granted re-arms it as a fresh event.
      pending <= (pending & ~grant_mask) | press;
      overrun <= |(press & pending & ~grant_mask);
      if (grant_valid) rr_ptr <= grant_id;
    end
  end

  // Handshake: evt_id is the queue head and holds steady while evt_valid is
  // high; the head is consumed at a clock edge where evt_valid && evt_ready.
  assign evt_valid = !fifo_empty;
  assign fifo_pop  = evt_valid && evt_ready;

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ID_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant_valid),
    .push_data (grant_id),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (evt_id)
  );

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Directed and randomized bench for btn_event_scheduler against a queue-based
// behavioural model evaluated once per clock.
module tb_btn_event_scheduler;

  localparam int N  = 5;
  localparam int TD = 4;
  localparam int FD = 4;
  localparam int W  = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_raw;
  logic         sample_tick;
  logic         evt_valid;
  logic [W-1:0] evt_id;
  logic         evt_ready;
  logic         overrun;

  btn_event_scheduler #(
    .N_BTN      (N),
    .TICK_DIV   (TD),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .sample_tick (sample_tick),
    .evt_valid   (evt_valid),
    .evt_id      (evt_id),
    .evt_ready   (evt_ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus drive values, applied once per cycle.
  logic [N-1:0] raw_drv   = '0;
  logic         ready_drv = 1'b0;
  logic         rst_drv   = 1'b0;
  bit           chk_en    = 1'b0;

  // Observations for scenario-level checks.
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  int           ovr_cnt = 0;
  logic         last_tick_obs, last_valid_obs, last_ovr_obs;

  // Behavioural model.
  int           m_age;
  bit [N-1:0]   m_hist[$];
  bit [N-1:0]   m_stable;
  bit [N-1:0]   m_pend;
  int           m_q[$];
  int           m_rr;
  bit           m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit         tick;
    bit [N-1:0] sync, press, old_pend;
    int         g;
    if (!rst_drv) begin
      m_age = 0;
      m_hist.delete();
      m_hist.push_back('0);
      m_hist.push_back('0);
      m_stable = '0;
      m_pend   = '0;
      m_q.delete();
      m_rr  = N - 1;
      m_ovr = 1'b0;
      return;
    end
    tick     = (m_age % TD) == (TD - 1);
    sync     = m_hist[0];
    press    = tick ? (sync & ~m_stable) : '0;
    old_pend = m_pend;
    g = -1;
    if (m_pend != 0 && m_q.size() < FD) begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    if (m_q.size() > 0 && ready_drv) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(g);
      m_pend[g] = 1'b0;
      m_rr = g;
    end
    m_ovr = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (press[i]) begin
        if (old_pend[i] && i != g) m_ovr = 1'b1;
        m_pend[i] = 1'b1;
      end
    end
    if (tick) m_stable = sync;
    m_hist.push_back(raw_drv);
    void'(m_hist.pop_front());
    m_age++;
  endtask

  // One clock: drive at the falling edge, compare, advance the model.
  task automatic cycle();
    btn_raw   = raw_drv;
    evt_ready = ready_drv;
    rst_n     = rst_drv;
    #1;
    last_tick_obs  = sample_tick;
    last_valid_obs = evt_valid;
    last_ovr_obs   = overrun;
    if (chk_en) begin
      chk("sample_tick", sample_tick, (m_age % TD) == (TD - 1));
      chk("evt_valid", evt_valid, m_q.size() > 0);
      chk("evt_id", evt_id, (m_q.size() > 0) ? m_q[0] : 0);
      chk("overrun", overrun, m_ovr);
      if (rst_drv && evt_valid === 1'b1 && ready_drv) got_q.push_back(evt_id);
      if (overrun === 1'b1) ovr_cnt++;
    end
    model_step();
    @(negedge clk);
  endtask

  task automatic hold(input logic [N-1:0] raw, input int n);
    raw_drv = raw;
    repeat (n) cycle();
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_id"}, got_q[i], exp_q[i]);
    got_q.delete();
  endtask

  initial begin
    int first_tick;
    logic [W-1:0] stall_id;
    btn_raw = '0; evt_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);

    // Reset
    rst_drv = 1'b0;
    cycle();
    chk_en = 1'b1;
    cycle();
    chk("reset_valid", evt_valid, 0);
    chk("reset_id", evt_id, 0);
    chk("reset_tick", sample_tick, 0);
    chk("reset_overrun", overrun, 0);
    rst_drv = 1'b1;

    // Single press held for many ticks
    ready_drv = 1'b1;
    hold(5'b00100, 12 * TD);
    exp_q = '{3'd2};
    check_events("single");
    hold('0, 2 * TD);
    got_q.delete();

    // Bounce between ticks, then settle high
    while (m_age % TD != 0) cycle();
    hold(5'b00001, 1);
    hold(5'b00000, 1);
    hold(5'b00001, 1);
    hold(5'b00001, 3 * TD);
    exp_q = '{3'd0};
    check_events("bounce");
    hold('0, 2 * TD);
    got_q.delete();

    // Simultaneous presses
    hold(5'b11010, 3 * TD);
    exp_q = '{3'd1, 3'd3, 3'd4};
    check_events("simul_a");
    hold('0, 2 * TD);
    got_q.delete();
    hold(5'b00011, 3 * TD);
    exp_q = '{3'd0, 3'd1};
    check_events("simul_b");
    hold('0, 2 * TD);
    got_q.delete();

    // Full queue with backpressure
    ready_drv = 1'b0;
    for (int b = 0; b < N; b++) hold(N'(1) << b, TD);
    hold('0, 2 * TD);
    chk("full_valid", evt_valid, 1);
    chk("full_head", evt_id, 0);
    chk("full_btn4_pending", m_pend[4], 1);
    stall_id = evt_id;
    hold('0, 3);
    chk("stall_id_stable", evt_id, stall_id);
    ready_drv = 1'b1;
    hold('0, 10);
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    check_events("backpressure");

    // Overrun on a re-press of a pending button
    ready_drv = 1'b0;
    ovr_cnt = 0;
    hold(5'b00001, TD);
    hold(5'b00010, TD);
    hold(5'b01000, TD);
    hold(5'b10000, TD);
    hold(5'b00100, TD);
    hold(5'b00000, TD);
    hold(5'b00100, TD);
    hold(5'b00000, 2 * TD);
    chk("overrun_pulses", ovr_cnt, 1);
    ready_drv = 1'b1;
    hold('0, 10);
    exp_q = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd2};
    check_events("overrun_drain");

    // Reset in the middle of operation
    ready_drv = 1'b0;
    hold(5'b00001, TD);
    hold(5'b00010, TD);
    hold(5'b00100, TD);
    hold(5'b00000, TD);
    chk("pre_reset_valid", evt_valid, 1);
    rst_drv = 1'b0;
    cycle();
    rst_drv = 1'b1;
    first_tick = -1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (k == 0) begin
        chk("post_reset_valid", last_valid_obs, 0);
        chk("post_reset_tick", last_tick_obs, 0);
        chk("post_reset_overrun", last_ovr_obs, 0);
      end
      if (last_tick_obs === 1'b1 && first_tick < 0) first_tick = k;
    end
    chk("first_tick_after_reset", first_tick, TD - 1);
    got_q.delete();

    // Randomized phase against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) raw_drv[$urandom_range(0, N - 1)] ^= 1'b1;
      ready_drv = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_event_scheduler.md
# btn_event_scheduler

- Shares one sampling timebase across all front-panel buttons, replacing per-button free-running counters.
- Detects a press event on each button at the shared sample tick and arbitrates simultaneous presses round-robin.
- Queues events and delivers them one at a time to the consumer FSM over a valid/ready handshake.
- Sits between the board button pins and the application control logic.

## Interface
- N_BTN, 5, number of buttons (≥2)
- TICK_DIV, 100_000, clk cycles per sample tick (≥2)
- FIFO_DEPTH, 4, event queue depth (power of 2, ≥2)

- clk  in  1  system clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- btn_raw  in  N_BTN  asynchronous button pins, 1 = pressed
- sample_tick  out  1  one-cycle strobe every TICK_DIV cycles
- evt_valid  out  1  queue head holds an event
- evt_id  out  $clog2(N_BTN)  index of the button at queue head
- evt_ready  in  1  consumer accepts head when evt_valid && evt_ready
- overrun  out  1  one-cycle pulse: a press was merged into an already-pending one

## Operation
- Reset (rst_n=0 at a clk edge) sets:
  - tick counter 0; sample_tick 0
  - synchronizers, btn_stable, pending 0; evt_valid 0, evt_id 0, overrun 0
  - queue empty; rr_ptr = N_BTN-1, so button 0 has first priority
- Reset mid-operation discards queued and pending events.
- Synchronizer: 2-FF per button every cycle → btn_sync.
- Tick counter:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - sample_tick = (cnt == TICK_DIV-1), combinational decode.
- On a tick cycle:
  - btn_stable <= btn_sync.
  - press[i] = btn_sync[i] & ~btn_stable[i].
- Press handling:
  - press[i] sets pending[i].
  - Release produces no event.
  - Bounce faster than the tick period is invisible.
- Arbiter (combinational grant, 1 per cycle):
  - Grants when pending ≠ 0 and queue not full.
  - Scans from rr_ptr+1 upward, wrapping N_BTN-1 → 0.
  - The granted id is pushed; pending[g] is cleared and rr_ptr <= g.
- Simultaneous set and clear of the same bit: set wins; pending stays 1 as a new event, no overrun.
- Overrun: press[i] while pending[i]=1 and i not granted that cycle → overrun pulses, event merged.
- Queue:
  - evt_valid = !empty; evt_id = head.
  - Pop on evt_valid && evt_ready.
  - Full blocks grant even if a pop occurs that cycle; no bypass.
  - Push and pop in the same cycle (not full, not empty) keep the count unchanged.

## Timing
- Tick at cycle T with a press captured → pending=1 at T+1 → grant/push at end of T+1 → evt_valid=1 at T+2, given empty queue and highest RR priority.
- Input to capture: btn_raw must be stable ≥2 cycles before the tick edge.
- Throughput: 1 event per cycle in and out.
- evt_id is stable while evt_valid=1 and evt_ready=0.
- overrun is registered, asserted the cycle after the offending tick.
- sample_tick first asserts at cycle TICK_DIV-1 after reset release.

## Structure
- Package btn_pkg:
  - N_BTN_DEFAULT, TICK_DIV_DEFAULT
  - BTN_ID_W = $clog2(N_BTN_DEFAULT)
  - typedef logic [BTN_ID_W-1:0] btn_id_t
- Sub-module event_fifo:
  - Synchronous FIFO of btn_id_t, parameter DEPTH.
  - Ports: push/pop, full/empty, head.
  - Same clk/rst_n.
- Tick counter, synchronizers, pending register and RR arbiter live in the top module.

## Test plan
Simulation parameters: TICK_DIV=4, N_BTN=5, FIFO_DEPTH=4.
- Single press:
  - Stimulus: btn_raw=5'b00100 held, evt_ready=1.
  - Required: evt_valid for exactly 1 cycle, 2 cycles after the first tick, evt_id=2.
  - Holding for 10 ticks yields no further events.
- Bounce:
  - Stimulus: btn 0 toggles every cycle for 3 cycles between ticks, then settles high.
  - Required: exactly 1 event, id 0.
- Simultaneous presses:
  - Stimulus: buttons 1, 3, 4 pressed at the same tick, evt_ready=1.
  - Required: ids 1, 3, 4 on consecutive cycles; next simultaneous 0+1 press → 0, then 1.
- Full / backpressure:
  - Stimulus: evt_ready=0; press-release buttons 0..4 one per tick.
  - Required: after 4 queued, button 4 stays pending.
  - Raise evt_ready → ids 0, 1, 2, 3, then 4; evt_id stable while stalled.
- Overrun:
  - Stimulus: evt_ready=0, queue full, button 2 pending; release then press button 2 again.
  - Required: overrun pulses once; only one id-2 event is delivered.
- Reset mid-operation:
  - Stimulus: rst_n=0 for 1 cycle with 3 queued events.
  - Required: next cycle evt_valid=0, sample_tick=0, overrun=0.
  - Counter restarts: first tick at cycle 3 after release.
